// File: rtl/ll_fifo_pkg.sv
// Shared definitions for the linked-list FIFO drain path.
package ll_fifo_pkg;

   // Depth of the drain output buffer.
   localparam int OUT_DEPTH = 2;

   // Widest queue index supported by the generic select type.
   localparam int QSEL_MAX_W = 8;

   // Generic queue-select/offset type, wide enough for any supported queue count.
   typedef logic [QSEL_MAX_W-1:0] qsel_t;

   // Queue-select width for n queues; never narrower than one bit.
   function automatic int sel_width(input int n);
      int w;
      if (n <= 2) begin
         w = 1;
      end else begin
         w = $clog2(n);
      end
      return w;
   endfunction

endpackage

// File: rtl/drain_out_buf.sv
// Two-entry valid/ready output buffer carrying a data word and its source queue.
module drain_out_buf
   import ll_fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int SEL_WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic [SEL_WIDTH-1:0] wr_sel,
   input  logic                 rd_ready,
   output logic                 valid,
   output logic [WIDTH-1:0]     rd_data,
   output logic [SEL_WIDTH-1:0] rd_sel,
   output logic [1:0]           count
);

   localparam int EW = WIDTH + SEL_WIDTH;

   logic [EW-1:0] slot0_q, slot0_d;
   logic [EW-1:0] slot1_q, slot1_d;
   logic [1:0]    count_q, count_d;
   logic          valid_q, valid_d;
   logic          deq_s;
   logic [EW-1:0] wr_entry_s;

   // Next-state of the two slots: slot0 is always the head, strict FIFO order.
   always_comb begin
      deq_s      = valid_q & rd_ready;
      wr_entry_s = {wr_sel, wr_data};
      slot0_d    = slot0_q;
      slot1_d    = slot1_q;
      count_d    = count_q;
      case (count_q)
         2'd0: begin
            if (wr_en) begin
               slot0_d = wr_entry_s;
               count_d = 2'd1;
            end else begin
               count_d = 2'd0;
            end
         end
         2'd1: begin
            if (deq_s && wr_en) begin
               slot0_d = wr_entry_s;
               count_d = 2'd1;
            end else if (deq_s) begin
               count_d = 2'd0;
            end else if (wr_en) begin
               slot1_d = wr_entry_s;
               count_d = 2'd2;
            end else begin
               count_d = 2'd1;
            end
         end
         2'd2: begin
            if (deq_s && wr_en) begin
               slot0_d = slot1_q;
               slot1_d = wr_entry_s;
               count_d = 2'd2;
            end else if (deq_s) begin
               slot0_d = slot1_q;
               count_d = 2'd1;
            end else begin
               count_d = 2'd2;
            end
         end
         default: begin
            count_d = 2'd0;
         end
      endcase
      valid_d = (count_d != 2'd0);
   end

   // Buffer state registers; reset drops any buffered words.
   always_ff @(posedge clk) begin
      if (!rst) begin
         slot0_q <= {EW{1'b0}};
         slot1_q <= {EW{1'b0}};
         count_q <= 2'd0;
         valid_q <= 1'b0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   assign valid   = valid_q;
   assign rd_data = slot0_q[WIDTH-1:0];
   assign rd_sel  = slot0_q[WIDTH +: SEL_WIDTH];
   assign count   = count_q;

endmodule

// File: rtl/ll_fifo_drain_arbiter.sv
// Round-robin drain of a shared linked-list FIFO into a small valid/ready stream.
module ll_fifo_drain_arbiter
   import ll_fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int NUM_FIFOS = 2,
   parameter int SEL_WIDTH = sel_width(NUM_FIFOS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_FIFOS-1:0] empty,
   input  logic [WIDTH-1:0]     ll_data_out,
   input  logic [NUM_FIFOS-1:0] en_mask,
   output logic                 pop,
   output logic [SEL_WIDTH-1:0] pop_sel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_WIDTH-1:0] out_sel
);

   localparam logic [SEL_WIDTH:0]   NUM_EXT  = (SEL_WIDTH+1)'(NUM_FIFOS);
   localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(NUM_FIFOS - 1);

   logic [SEL_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NUM_FIFOS-1:0]   elig_s;
   logic [2*NUM_FIFOS-1:0] dbl_s;
   logic [NUM_FIFOS-1:0]   rot_s;
   logic [NUM_FIFOS-1:0]   scan_s;
   logic                   found_s;
   qsel_t                  offset_s;
   logic [SEL_WIDTH:0]     sum_s;
   logic [SEL_WIDTH:0]     diff_s;
   logic [SEL_WIDTH-1:0]   pick_s;
   logic                   deq_s;
   logic                   space_s;
   logic                   pop_s;
   logic [1:0]             count_s;

   // Pop only when reset is released, the buffer can take a word and some queue is eligible.
   always_comb begin
      elig_s  = ~empty & en_mask;
      deq_s   = out_valid & out_ready;
      space_s = (count_s < 2'(OUT_DEPTH)) | deq_s;
      pop_s   = rst & space_s & (|elig_s);
   end

   // Cyclic first-eligible search starting at rr_ptr: rotate, find lowest set bit, map back.
   always_comb begin
      dbl_s    = {elig_s, elig_s} >> rr_ptr_q;
      rot_s    = dbl_s[NUM_FIFOS-1:0];
      scan_s   = {NUM_FIFOS{1'b0}};
      found_s  = 1'b0;
      offset_s = {QSEL_MAX_W{1'b0}};
      for (int i = 0; i < NUM_FIFOS; i++) begin
         scan_s = rot_s >> i;
         if (!found_s && scan_s[0]) begin
            found_s  = 1'b1;
            offset_s = qsel_t'(i);
         end else begin
            found_s  = found_s;
         end
      end
      sum_s  = {1'b0, rr_ptr_q} + {1'b0, offset_s[SEL_WIDTH-1:0]};
      diff_s = sum_s - NUM_EXT;
      if (sum_s >= NUM_EXT) begin
         pick_s = diff_s[SEL_WIDTH-1:0];
      end else begin
         pick_s = sum_s[SEL_WIDTH-1:0];
      end
   end

   // Round-robin pointer advances past the queue just popped.
   always_comb begin
      if (pop_s) begin
         if (pick_s == LAST_SEL) begin
            rr_ptr_d = {SEL_WIDTH{1'b0}};
         end else begin
            rr_ptr_d = pick_s + SEL_WIDTH'(1);
         end
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr_q <= {SEL_WIDTH{1'b0}};
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign pop     = pop_s;
   assign pop_sel = pop_s ? pick_s : {SEL_WIDTH{1'b0}};

   drain_out_buf #(
      .WIDTH     (WIDTH),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_out_buf (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (pop_s),
      .wr_data  (ll_data_out),
      .wr_sel   (pick_s),
      .rd_ready (out_ready),
      .valid    (out_valid),
      .rd_data  (out_data),
      .rd_sel   (out_sel),
      .count    (count_s)
   );

endmodule

// File: tb/tb_ll_fifo_drain_arbiter.sv
// Randomized bench for ll_fifo_drain_arbiter against a queue-level reference model.
module tb_ll_fifo_drain_arbiter;

   localparam int W  = 8;
   localparam int N  = 2;
   localparam int SW = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  empty;
   logic [N-1:0]  en_mask;
   logic [W-1:0]  ll_data_out;
   logic          pop;
   logic [SW-1:0] pop_sel;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [SW-1:0] out_sel;

   logic [W-1:0]  head_v [N];

   // Shared FIFO model: one queue of words per logical queue.
   logic [W-1:0]  fq0 [$];
   logic [W-1:0]  fq1 [$];
   // Expected output stream contents, head first.
   logic [W-1:0]  md [$];
   int            ms [$];
   int            m_rr;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [7:0]    next_word = 8'h40;

   always #5 clk = ~clk;

   // Fall-through head of whichever queue the arbiter is selecting.
   assign ll_data_out = head_v[pop_sel];

   ll_fifo_drain_arbiter #(.WIDTH(W), .NUM_FIFOS(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .empty       (empty),
      .ll_data_out (ll_data_out),
      .en_mask     (en_mask),
      .pop         (pop),
      .pop_sel     (pop_sel),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_sel     (out_sel)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic refresh();
      empty[0]  = (fq0.size() == 0);
      empty[1]  = (fq1.size() == 0);
      head_v[0] = (fq0.size() == 0) ? 8'h00 : fq0[0];
      head_v[1] = (fq1.size() == 0) ? 8'h00 : fq1[0];
   endtask

   task automatic push_word(input int q);
      if (q == 0) fq0.push_back(next_word);
      else        fq1.push_back(next_word);
      next_word = next_word + 8'd1;
   endtask

   // One clock cycle: apply inputs, check against the model, then advance the model.
   task automatic step(input logic rst_i, input logic [N-1:0] en_i, input logic rdy_i);
      logic [N-1:0] elig;
      logic [N-1:0] tmp;
      logic         exp_pop;
      int           exp_sel;
      bit           deq;
      bit           found;
      int           idx;
      @(negedge clk);
      rst       = rst_i;
      en_mask   = en_i;
      out_ready = rdy_i;
      refresh();
      #1;
      elig[0] = (fq0.size() != 0) && en_i[0];
      elig[1] = (fq1.size() != 0) && en_i[1];
      deq     = (md.size() != 0) && rdy_i;
      exp_pop = rst_i && ((md.size() < 2) || deq) && (elig != '0);
      exp_sel = 0;
      found   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (m_rr + k) % N;
         tmp = elig >> idx;
         if (!found && tmp[0]) begin
            found   = 1;
            exp_sel = idx;
         end
      end
      check_eq("pop", 32'(pop), 32'(exp_pop));
      check_eq("pop_sel", 32'(pop_sel), exp_pop ? exp_sel : 0);
      check_eq("out_valid", 32'(out_valid), 32'(md.size() != 0));
      if (md.size() != 0) begin
         check_eq("out_data", 32'(out_data), 32'(md[0]));
         check_eq("out_sel", 32'(out_sel), ms[0]);
      end
      if (pop) begin
         tmp = empty >> pop_sel;
         check_eq("pop_on_empty", 32'(tmp[0]), 32'd0);
      end
      @(posedge clk);
      if (!rst_i) begin
         md.delete();
         ms.delete();
         m_rr = 0;
      end else begin
         if (deq) begin
            void'(md.pop_front());
            void'(ms.pop_front());
         end
         if (exp_pop) begin
            if (exp_sel == 0) md.push_back(fq0.pop_front());
            else              md.push_back(fq1.pop_front());
            ms.push_back(exp_sel);
            m_rr = (exp_sel + 1) % N;
         end
      end
   endtask

   initial begin
      rst       = 1'b0;
      en_mask   = 2'b11;
      out_ready = 1'b1;
      m_rr      = 0;
      fq0.push_back(8'h10); fq0.push_back(8'h11);
      fq1.push_back(8'h20); fq1.push_back(8'h21);
      refresh();

      // Reset held three cycles with both queues non-empty, then alternate drain.
      for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 1'b1);
      for (int i = 0; i < 7; i++) step(1'b1, 2'b11, 1'b1);

      // Back-pressure: two pops fill the buffer, then release.
      fq0.push_back(8'h10); fq0.push_back(8'h11); fq0.push_back(8'h12);
      fq1.push_back(8'h20); fq1.push_back(8'h21); fq1.push_back(8'h22);
      for (int i = 0; i < 4; i++) step(1'b1, 2'b11, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b1, 2'b11, 1'b1);

      // Only queue1 holds data.
      for (int i = 0; i < 5; i++) push_word(1);
      for (int i = 0; i < 10; i++) step(1'b1, 2'b11, 1'($urandom_range(0, 1)));

      // Enable mask restricts the drain; switching it keeps buffered words.
      for (int i = 0; i < 4; i++) begin push_word(0); push_word(1); end
      for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 2'b01, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 2'b11, 1'b1);

      // Reset with a full buffer drops the words and clears the pointer.
      for (int i = 0; i < 3; i++) begin push_word(0); push_word(1); end
      for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 1'b0);
      step(1'b0, 2'b11, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 2'b11, 1'b1);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 2) == 0) push_word(0);
         if ($urandom_range(0, 2) == 0) push_word(1);
         step(($urandom_range(0, 49) != 0),
              2'($urandom_range(0, 3)),
              ($urandom_range(0, 3) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
